// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter slice.
//   WIDTH   : data byte width shared with the UART TX top level
//   state_e : arbiter FSM encoding (IDLE, LOAD, WAIT_BUSY, WAIT_DONE)
// No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. The search starts at rr_ptr and wraps
// modulo NUM_REQ; the first set request found is the winner.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  IDX_W    index where the search starts
//   winner out NUM_REQ  one-hot winner (0 when nothing requests)
//   index  out IDX_W    binary index of the winner
//   any    out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  // Walk the candidates from the farthest offset down to offset 0 so that the
  // last hit written is the one closest to rr_ptr.
  always_comb begin
    int cand;
    winner = '0;
    index  = '0;
    any    = 1'b0;
    cand   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
        index        = IDX_W'(cand);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Picks a requester, latches its byte and parity controls, strobes the load,
// follows tx_busy through the frame and acknowledges the winner.
// Optional build macro: UART_TX_ARB_PER_REQ_PARITY_EN (per-requester parity
// inputs replace the global parity_enable/parity_type).
// Ports:
//   CLK, RST             clock (rising) / async active-high reset
//   req, req_data        per-requester request level and byte
//   parity_enable/type   global parity controls
//   req_parity_enable/type  per-requester parity (macro only)
//   tx_busy              transmitter busy flag
//   tx_data_valid        one-cycle load strobe
//   tx_p_data            byte to transmitter
//   tx_parity_enable/type parity controls to transmitter
//   grant                one-hot frame owner
//   ack                  one-cycle completion pulse to the owner
//   timeout_err          one-cycle pulse when busy never rose
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = uart_tx_arbiter_pkg::WIDTH,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     parity_enable,
  input  logic                     parity_type,
`ifdef UART_TX_ARB_PER_REQ_PARITY_EN
  input  logic [NUM_REQ-1:0]       req_parity_enable,
  input  logic [NUM_REQ-1:0]       req_parity_type,
`endif
  input  logic                     tx_busy,
  output logic                     tx_data_valid,
  output logic [WIDTH-1:0]         tx_p_data,
  output logic                     tx_parity_enable,
  output logic                     tx_parity_type,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]     p_data_q, p_data_d;
  logic                 par_en_q, par_en_d;
  logic                 par_type_q, par_type_d;
  logic                 dv_q, dv_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [IDX_W-1:0]     ptr_after_winner;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // Fairness: the next search always begins just past the last owner,
  // whether its frame completed or timed out.
  assign ptr_after_winner = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      dv_q       <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      dv_q       <= dv_d;
      timeout_q  <= timeout_d;
    end
  end

  // The load strobe register is set while the FSM sits in LOAD, so the
  // transmitter sees it in the cycle after LOAD (two edges after the grant).
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    dv_d       = 1'b0;
    ack_d      = '0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Hold off while the transmitter is still finishing something.
        if (pick_any && !tx_busy) begin
          grant_d  = pick_onehot;
          idx_d    = pick_idx;
          p_data_d = req_data[pick_idx*WIDTH +: WIDTH];
`ifdef UART_TX_ARB_PER_REQ_PARITY_EN
          par_en_d   = req_parity_enable[pick_idx];
          par_type_d = req_parity_type[pick_idx];
`else
          par_en_d   = parity_enable;
          par_type_d = parity_type;
`endif
          state_d  = LOAD;
        end
      end

      LOAD: begin
        dv_d    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          rr_ptr_d  = ptr_after_winner;
          grant_d   = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          ack_d    = grant_q;
          rr_ptr_d = ptr_after_winner;
          grant_d  = '0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx_data_valid    = dv_q;
  assign tx_p_data        = p_data_q;
  assign tx_parity_enable = par_en_q;
  assign tx_parity_type   = par_type_q;
  assign grant            = grant_q;
  assign ack              = ack_q;
  assign timeout_err      = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NUM_REQ=4, WIDTH=8, BUSY_TIMEOUT=4).
// The transmitter busy flag is driven by hand in each step.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int WIDTH        = 8;
  localparam int BUSY_TIMEOUT = 4;

  logic                     CLK = 1'b0;
  logic                     RST;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     parity_enable;
  logic                     parity_type;
`ifdef UART_TX_ARB_PER_REQ_PARITY_EN
  logic [NUM_REQ-1:0]       req_parity_enable;
  logic [NUM_REQ-1:0]       req_parity_type;
`endif
  logic                     tx_busy;
  logic                     tx_data_valid;
  logic [WIDTH-1:0]         tx_p_data;
  logic                     tx_parity_enable;
  logic                     tx_parity_type;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic                     timeout_err;

  int errorCount = 0;
  int checkCount = 0;

  logic [31:0] dataAll;
  logic [3:0]  expGrant;
  logic [7:0]  expByte;
  logic        expParEn;
  logic        expParType;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .WIDTH        (WIDTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .req               (req),
    .req_data          (req_data),
    .parity_enable     (parity_enable),
    .parity_type       (parity_type),
`ifdef UART_TX_ARB_PER_REQ_PARITY_EN
    .req_parity_enable (req_parity_enable),
    .req_parity_type   (req_parity_type),
`endif
    .tx_busy           (tx_busy),
    .tx_data_valid     (tx_data_valid),
    .tx_p_data         (tx_p_data),
    .tx_parity_enable  (tx_parity_enable),
    .tx_parity_type    (tx_parity_type),
    .grant             (grant),
    .ack               (ack),
    .timeout_err       (timeout_err)
  );

  // 10-unit clock period.
  always #5 CLK = ~CLK;

  // Drive the inputs, then let one rising edge pass and settle 1 unit.
  task automatic applyStimulus(input logic [3:0] reqV, input logic [31:0] dataV,
                               input logic busyV);
    req      = reqV;
    req_data = dataV;
    tx_busy  = busyV;
    @(posedge CLK);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RST           = 1'b1;
    req           = '0;
    req_data      = '0;
    tx_busy       = 1'b0;
    parity_enable = 1'b1;
    parity_type   = 1'b0;
`ifdef UART_TX_ARB_PER_REQ_PARITY_EN
    req_parity_enable = 4'b0010;
    req_parity_type   = 4'b0010;
`endif

    // Reset state: every output low even with global parity enabled.
    applyStimulus(4'b0000, 32'h0, 1'b0);
    applyStimulus(4'b1111, 32'hFFFFFFFF, 1'b0);
    checkOutput("rst_grant", grant, 4'b0000);
    checkOutput("rst_dv", tx_data_valid, 1'b0);
    checkOutput("rst_pdata", tx_p_data, 8'h00);
    checkOutput("rst_par_en", tx_parity_enable, 1'b0);
    checkOutput("rst_ack", ack, 4'b0000);
    checkOutput("rst_timeout", timeout_err, 1'b0);
    req = '0;
    RST = 1'b0;

    // Single requester 2, byte A5, busy held for 10 edges.
    $display("[TB] single requester");
    applyStimulus(4'b0100, 32'h00A50000, 1'b0);
    checkOutput("s_grant", grant, 4'b0100);
    checkOutput("s_pdata", tx_p_data, 8'hA5);
    checkOutput("s_dv_early", tx_data_valid, 1'b0);
`ifdef UART_TX_ARB_PER_REQ_PARITY_EN
    checkOutput("s_par_en", tx_parity_enable, 1'b0);
`else
    checkOutput("s_par_en", tx_parity_enable, 1'b1);
`endif
    applyStimulus(4'b0100, 32'h00A50000, 1'b0);
    checkOutput("s_dv", tx_data_valid, 1'b1);
    checkOutput("s_dv_pdata", tx_p_data, 8'hA5);
    applyStimulus(4'b0100, 32'h00A50000, 1'b1);
    checkOutput("s_dv_off", tx_data_valid, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b0100, 32'h00A50000, 1'b1);
      checkOutput("s_busy_grant", grant, 4'b0100);
      checkOutput("s_busy_ack", ack, 4'b0000);
      checkOutput("s_busy_dv", tx_data_valid, 1'b0);
    end
    applyStimulus(4'b0000, 32'h00A50000, 1'b0);
    checkOutput("s_ack", ack, 4'b0100);
    checkOutput("s_grant_clr", grant, 4'b0000);
    applyStimulus(4'b0000, 32'h0, 1'b0);
    checkOutput("s_ack_once", ack, 4'b0000);

    // Timeout: pointer is now 3, requests 1 and 3, busy never rises.
    $display("[TB] timeout");
    applyStimulus(4'b1010, 32'h55006600, 1'b0);
    checkOutput("t_grant", grant, 4'b1000);
    checkOutput("t_pdata", tx_p_data, 8'h55);
    applyStimulus(4'b1010, 32'h55006600, 1'b0);
    checkOutput("t_dv", tx_data_valid, 1'b1);
    for (int i = 0; i < BUSY_TIMEOUT - 1; i++) begin
      applyStimulus(4'b1010, 32'h55006600, 1'b0);
      checkOutput("t_early", timeout_err, 1'b0);
    end
    applyStimulus(4'b1010, 32'h55006600, 1'b0);
    checkOutput("t_pulse", timeout_err, 1'b1);
    checkOutput("t_no_ack", ack, 4'b0000);
    checkOutput("t_grant_clr", grant, 4'b0000);
    applyStimulus(4'b1010, 32'h55006600, 1'b0);
    checkOutput("t_next_grant", grant, 4'b0010);
    checkOutput("t_pulse_end", timeout_err, 1'b0);
    checkOutput("t_next_pdata", tx_p_data, 8'h66);
    applyStimulus(4'b1010, 32'h55006600, 1'b0);
    applyStimulus(4'b1010, 32'h55006600, 1'b1);
    applyStimulus(4'b0000, 32'h55006600, 1'b0);
    checkOutput("t_next_ack", ack, 4'b0010);

    // Withdrawal: requester 1 latches 3C, then drops req and zeroes its byte.
    $display("[TB] withdrawal");
    applyStimulus(4'b0010, 32'h00003C00, 1'b0);
    checkOutput("w_grant", grant, 4'b0010);
    checkOutput("w_pdata", tx_p_data, 8'h3C);
    parity_enable = 1'b0;
    parity_type   = 1'b1;
    applyStimulus(4'b0000, 32'h00000000, 1'b0);
    checkOutput("w_dv", tx_data_valid, 1'b1);
    checkOutput("w_pdata_hold", tx_p_data, 8'h3C);
    checkOutput("w_par_en_hold", tx_parity_enable, 1'b1);
`ifdef UART_TX_ARB_PER_REQ_PARITY_EN
    checkOutput("w_par_type_hold", tx_parity_type, 1'b1);
`else
    checkOutput("w_par_type_hold", tx_parity_type, 1'b0);
`endif
    applyStimulus(4'b0000, 32'h00000000, 1'b1);
    applyStimulus(4'b0000, 32'h00000000, 1'b1);
    checkOutput("w_pdata_busy", tx_p_data, 8'h3C);
    applyStimulus(4'b0000, 32'h00000000, 1'b0);
    checkOutput("w_ack", ack, 4'b0010);
    parity_enable = 1'b1;
    parity_type   = 1'b0;

    // Reset in WAIT_DONE: outputs clear without waiting for an edge, and the
    // pointer returns to 0 (1001 must then grant requester 0, not 3).
    $display("[TB] reset mid-frame");
    applyStimulus(4'b0100, 32'h00770000, 1'b0);
    checkOutput("r_grant", grant, 4'b0100);
    applyStimulus(4'b0100, 32'h00770000, 1'b0);
    applyStimulus(4'b0100, 32'h00770000, 1'b1);
    applyStimulus(4'b0100, 32'h00770000, 1'b1);
    checkOutput("r_grant_held", grant, 4'b0100);
    RST = 1'b1;
    #1;
    checkOutput("r_async_grant", grant, 4'b0000);
    checkOutput("r_async_pdata", tx_p_data, 8'h00);
    checkOutput("r_async_par", tx_parity_enable, 1'b0);
    applyStimulus(4'b1001, 32'h99000011, 1'b0);
    checkOutput("r_hold_grant", grant, 4'b0000);
    RST = 1'b0;
    applyStimulus(4'b1001, 32'h99000011, 1'b0);
    checkOutput("r_first_grant", grant, 4'b0001);
    checkOutput("r_first_pdata", tx_p_data, 8'h11);
    RST = 1'b1;
    #1;
    RST = 1'b0;

    // All requesting: grants rotate 0,1,2,3,0 with one load strobe each.
    $display("[TB] all requesting");
    dataAll = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      expGrant = 4'b0001 << (k % 4);
      expByte  = dataAll[(k % 4)*8 +: 8];
`ifdef UART_TX_ARB_PER_REQ_PARITY_EN
      expParEn   = ((k % 4) == 1);
      expParType = ((k % 4) == 1);
`else
      expParEn   = 1'b1;
      expParType = 1'b0;
`endif
      applyStimulus(4'b1111, dataAll, 1'b0);
      checkOutput("a_grant", grant, expGrant);
      checkOutput("a_pdata", tx_p_data, expByte);
      checkOutput("a_dv_pre", tx_data_valid, 1'b0);
      checkOutput("a_par_en", tx_parity_enable, expParEn);
      checkOutput("a_par_type", tx_parity_type, expParType);
      applyStimulus(4'b1111, dataAll, 1'b0);
      checkOutput("a_dv", tx_data_valid, 1'b1);
      applyStimulus(4'b1111, dataAll, 1'b1);
      checkOutput("a_dv_post", tx_data_valid, 1'b0);
      applyStimulus(4'b1111, dataAll, 1'b1);
      checkOutput("a_no_ack", ack, 4'b0000);
      applyStimulus(4'b1111, dataAll, 1'b0);
      checkOutput("a_ack", ack, expGrant);
      checkOutput("a_gap_grant", grant, 4'b0000);
    end

    // Busy seen in IDLE blocks the next grant until it clears.
    $display("[TB] busy in idle");
    applyStimulus(4'b0001, dataAll, 1'b1);
    checkOutput("b_blocked1", grant, 4'b0000);
    applyStimulus(4'b0001, dataAll, 1'b1);
    checkOutput("b_blocked2", grant, 4'b0000);
    applyStimulus(4'b0001, dataAll, 1'b0);
    checkOutput("b_grant", grant, 4'b0001);
    checkOutput("b_pdata", tx_p_data, 8'h11);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
